// File: rtl/uart_cmd_assembler.sv
// rtl/uart_cmd_assembler.sv - pairs UART receiver bytes into 16-bit commands
//
// Consumes bytes from the UART receiver (rx_data/rx_rdy level handshake,
// acknowledged with a one-cycle clr_rx_rdy), pairs them high byte first into
// a 16-bit command and presents it on cmd/cmd_rdy until clr_cmd_rdy.
// A pending high byte is dropped if the low byte does not arrive within
// TO_CYCLES clocks, so framing recovers after a lost byte.
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   rx_data[7:0]  - received byte, valid while rx_rdy is high
//   rx_rdy        - receiver byte-valid level
//   clr_rx_rdy    - one-cycle acknowledge to the receiver
//   cmd[15:0]     - assembled command {high byte, low byte}
//   cmd_rdy       - command valid level
//   clr_cmd_rdy   - consumer acknowledge, clears cmd_rdy
//   overrun       - pulse: a completed command replaced an unacknowledged one
//   timeout       - pulse: a pending high byte was discarded
module uart_cmd_assembler #(
  parameter int TO_CYCLES = 52080
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [7:0]  rx_data,
  input  logic        rx_rdy,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        overrun,
  output logic        timeout
);

  localparam int CW = $clog2(TO_CYCLES);
  localparam logic [CW-1:0] TO_LAST = CW'(TO_CYCLES - 1);

  localparam logic [0:0] IDLE    = 1'b0;
  localparam logic [0:0] WAIT_LO = 1'b1;

  logic [0:0]    state_q, state_d;
  logic          rx_rdy_q, rx_rdy_d;
  logic [CW-1:0] to_cnt_q, to_cnt_d;
  logic [7:0]    hi_byte_q, hi_byte_d;
  logic [15:0]   cmd_q, cmd_d;
  logic          cmd_rdy_q, cmd_rdy_d;
  logic          clr_rx_rdy_q, clr_rx_rdy_d;
  logic          overrun_q, overrun_d;
  logic          timeout_q, timeout_d;

  logic          byte_evt;
  logic          complete;

  always_comb begin
    // Only the rising edge of rx_rdy consumes a byte; a held level is ignored.
    byte_evt     = rx_rdy & ~rx_rdy_q;
    complete     = 1'b0;
    state_d      = state_q;
    rx_rdy_d     = rx_rdy;
    to_cnt_d     = to_cnt_q;
    hi_byte_d    = hi_byte_q;
    cmd_d        = cmd_q;
    clr_rx_rdy_d = byte_evt;
    overrun_d    = 1'b0;
    timeout_d    = 1'b0;

    case (state_q)
      IDLE: begin
        if (byte_evt) begin
          hi_byte_d = rx_data;
          to_cnt_d  = '0;
          state_d   = WAIT_LO;
        end
      end
      WAIT_LO: begin
        // A byte arriving on the terminal count still completes the command.
        if (byte_evt) begin
          complete  = 1'b1;
          cmd_d     = {hi_byte_q, rx_data};
          overrun_d = cmd_rdy_q & ~clr_cmd_rdy;
          state_d   = IDLE;
        end else if (to_cnt_q == TO_LAST) begin
          hi_byte_d = 8'h00;
          to_cnt_d  = '0;
          timeout_d = 1'b1;
          state_d   = IDLE;
        end else begin
          to_cnt_d = to_cnt_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Completion has priority over the consumer's clear in the same cycle.
    if (complete) begin
      cmd_rdy_d = 1'b1;
    end else if (clr_cmd_rdy) begin
      cmd_rdy_d = 1'b0;
    end else begin
      cmd_rdy_d = cmd_rdy_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      rx_rdy_q     <= 1'b0;
      to_cnt_q     <= '0;
      hi_byte_q    <= 8'h00;
      cmd_q        <= 16'h0000;
      cmd_rdy_q    <= 1'b0;
      clr_rx_rdy_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      rx_rdy_q     <= rx_rdy_d;
      to_cnt_q     <= to_cnt_d;
      hi_byte_q    <= hi_byte_d;
      cmd_q        <= cmd_d;
      cmd_rdy_q    <= cmd_rdy_d;
      clr_rx_rdy_q <= clr_rx_rdy_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign clr_rx_rdy = clr_rx_rdy_q;
  assign cmd        = cmd_q;
  assign cmd_rdy    = cmd_rdy_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// tb/tb_uart_cmd_assembler.sv - self-checking bench for uart_cmd_assembler
module tb_uart_cmd_assembler;

  localparam int TO = 100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_rdy = 1'b0;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        overrun;
  logic        timeout;

  uart_cmd_assembler #(.TO_CYCLES(TO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .rx_data     (rx_data),
    .rx_rdy      (rx_rdy),
    .clr_rx_rdy  (clr_rx_rdy),
    .cmd         (cmd),
    .cmd_rdy     (cmd_rdy),
    .clr_cmd_rdy (clr_cmd_rdy),
    .overrun     (overrun),
    .timeout     (timeout)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_clr = 0;
  int n_ovr = 0;
  int n_to  = 0;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Model: a pending high byte is remembered with the cycle number it
  // arrived on; it expires exactly TO cycles later unless a byte comes first.
  int          m_cyc = 0;
  bit          m_prev_rx = 1'b0;
  bit          m_have_hi = 1'b0;
  logic [7:0]  m_hi = 8'h00;
  int          m_hi_cyc = 0;
  logic [15:0] m_cmd = 16'h0000;
  bit          m_cmd_rdy = 1'b0;
  bit          m_clr_rx = 1'b0;
  bit          m_ovr = 1'b0;
  bit          m_to = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_prev_rx = 1'b0;
      m_have_hi = 1'b0;
      m_cmd     = 16'h0000;
      m_cmd_rdy = 1'b0;
      m_clr_rx  = 1'b0;
      m_ovr     = 1'b0;
      m_to      = 1'b0;
    end else begin
      bit evt;
      bit done;
      m_cyc++;
      evt       = rx_rdy && !m_prev_rx;
      m_prev_rx = rx_rdy;
      m_clr_rx  = evt;
      m_ovr     = 1'b0;
      m_to      = 1'b0;
      done      = evt && m_have_hi;
      if (done) begin
        m_ovr     = m_cmd_rdy && !clr_cmd_rdy;
        m_cmd     = {m_hi, rx_data};
        m_have_hi = 1'b0;
      end else if (evt) begin
        m_have_hi = 1'b1;
        m_hi      = rx_data;
        m_hi_cyc  = m_cyc;
      end else if (m_have_hi && (m_cyc - m_hi_cyc == TO)) begin
        m_have_hi = 1'b0;
        m_to      = 1'b1;
      end
      if (done) m_cmd_rdy = 1'b1;
      else if (clr_cmd_rdy) m_cmd_rdy = 1'b0;
    end
  end

  always @(negedge clk) begin
    chk("cmd", cmd, m_cmd);
    chk("cmd_rdy", 16'(cmd_rdy), 16'(m_cmd_rdy));
    chk("clr_rx_rdy", 16'(clr_rx_rdy), 16'(m_clr_rx));
    chk("overrun", 16'(overrun), 16'(m_ovr));
    chk("timeout", 16'(timeout), 16'(m_to));
    if (clr_rx_rdy === 1'b1) n_clr++;
    if (overrun === 1'b1) n_ovr++;
    if (timeout === 1'b1) n_to++;
  end

  // Called at a negedge; the byte is sampled on the next posedge.
  task automatic send_byte(input logic [7:0] b, input int hold, input logic clr);
    rx_data     = b;
    rx_rdy      = 1'b1;
    clr_cmd_rdy = clr;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    repeat (hold - 1) @(negedge clk);
    rx_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic pulse_clr();
    clr_cmd_rdy = 1'b1;
    @(negedge clk);
    clr_cmd_rdy = 1'b0;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  int s_clr, s_ovr, s_to;

  initial begin
    // Reset with rx_rdy already high.
    rx_rdy  = 1'b1;
    rx_data = 8'h9A;
    idle(3);
    chk("rst_cmd", cmd, 16'h0000);
    chk("rst_cmd_rdy", 16'(cmd_rdy), 16'h0);
    chk("rst_clr_rx_rdy", 16'(clr_rx_rdy), 16'h0);
    chk("rst_overrun", 16'(overrun), 16'h0);
    chk("rst_timeout", 16'(timeout), 16'h0);
    s_clr = n_clr;
    #2 rst_n = 1'b1;
    idle(4);
    rx_rdy = 1'b0;
    idle(1);
    chk("rel_clr_count", 16'(n_clr - s_clr), 16'd1);
    send_byte(8'hBC, 1, 1'b0);
    chk("rel_cmd", cmd, 16'h9ABC);
    pulse_clr();

    // Normal pair with a long-held rx_rdy.
    s_clr = n_clr;
    send_byte(8'hA5, 5, 1'b0);
    send_byte(8'h3C, 5, 1'b0);
    chk("pair_clr_count", 16'(n_clr - s_clr), 16'd2);
    chk("pair_cmd", cmd, 16'hA53C);
    chk("pair_cmd_rdy", 16'(cmd_rdy), 16'h1);
    pulse_clr();
    chk("pair_cleared", 16'(cmd_rdy), 16'h0);
    chk("pair_cmd_hold", cmd, 16'hA53C);

    // Overrun, then the same with clear in the completion cycle.
    s_ovr = n_ovr;
    send_byte(8'h12, 1, 1'b0);
    send_byte(8'h34, 1, 1'b0);
    send_byte(8'h56, 1, 1'b0);
    chk("ovr_cmd_hold", cmd, 16'h1234);
    send_byte(8'h78, 1, 1'b0);
    chk("ovr_cmd", cmd, 16'h5678);
    chk("ovr_count", 16'(n_ovr - s_ovr), 16'd1);
    s_ovr = n_ovr;
    send_byte(8'h87, 1, 1'b0);
    send_byte(8'h65, 1, 1'b1);
    chk("noovr_cmd", cmd, 16'h8765);
    chk("noovr_cmd_rdy", 16'(cmd_rdy), 16'h1);
    chk("noovr_count", 16'(n_ovr - s_ovr), 16'd0);
    pulse_clr();

    // Timeout with no second byte, then a fresh pair.
    s_to = n_to;
    send_byte(8'hFF, 1, 1'b0);
    idle(110);
    chk("to_count", 16'(n_to - s_to), 16'd1);
    chk("to_cmd_rdy", 16'(cmd_rdy), 16'h0);
    send_byte(8'h01, 1, 1'b0);
    send_byte(8'h02, 1, 1'b0);
    chk("to_after_cmd", cmd, 16'h0102);
    pulse_clr();

    // Low byte at N+99: completes.
    s_to = n_to;
    send_byte(8'h33, 1, 1'b0);
    idle(TO - 3);
    send_byte(8'h44, 1, 1'b0);
    chk("b99_cmd", cmd, 16'h3344);
    chk("b99_to", 16'(n_to - s_to), 16'd0);
    pulse_clr();

    // Low byte at N+100, on the terminal count: byte wins.
    s_to = n_to;
    send_byte(8'h55, 1, 1'b0);
    idle(TO - 2);
    send_byte(8'h66, 1, 1'b0);
    chk("b100_cmd", cmd, 16'h5566);
    chk("b100_to", 16'(n_to - s_to), 16'd0);
    pulse_clr();

    // Byte at N+101 arrives after the timeout and starts a new pair.
    s_to = n_to;
    send_byte(8'h77, 1, 1'b0);
    idle(TO - 1);
    send_byte(8'h88, 1, 1'b0);
    chk("b101_rdy", 16'(cmd_rdy), 16'h0);
    send_byte(8'h99, 1, 1'b0);
    chk("b101_cmd", cmd, 16'h8899);
    chk("b101_to", 16'(n_to - s_to), 16'd1);
    pulse_clr();

    // Reset while a high byte is pending.
    send_byte(8'hAA, 1, 1'b0);
    #2 rst_n = 1'b0;
    idle(2);
    chk("midrst_cmd", cmd, 16'h0000);
    #2 rst_n = 1'b1;
    idle(1);
    send_byte(8'h11, 1, 1'b0);
    send_byte(8'h22, 1, 1'b0);
    chk("midrst_new_cmd", cmd, 16'h1122);
    idle(3);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
